// File: rtl/frame_streamer_if.sv
// frame_streamer_if: pixel stream bundle; master drives out_valid/pixel_out/sof/eol/eof, slave drives out_ready
interface frame_streamer_if #(
  parameter int DATA_W = 8
);
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] pixel_out;
  logic                     sof;
  logic                     eol;
  logic                     eof;
  modport master (output out_valid, pixel_out, sof, eol, eof, input out_ready);
  modport slave (input out_valid, pixel_out, sof, eol, eof, output out_ready);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: raster pixel source from sync-read RAM (clk, rst, start, base_addr, busy, done, mem_rd_en/mem_addr/mem_rdata, st stream); FRAME_STREAMER_PAD_EN adds a zero border
module frame_streamer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [DATA_W-1:0] mem_rdata,
  frame_streamer_if.master         st
);
`ifdef FRAME_STREAMER_PAD_EN
  localparam int FW = IMG_W + 2;
  localparam int FH = IMG_H + 2;
`else
  localparam int FW = IMG_W;
  localparam int FH = IMG_H;
`endif
  localparam int CW = $clog2(FW);
  localparam int RW = $clog2(FH);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr;
  logic s1_v;
  logic [2:0] s1_m;
  logic [DATA_W+2:0] fifo [3];
  logic [DATA_W+2:0] head;
  logic [1:0] wp, rp, cnt;
  logic issue, last_col, last_row, pop;
  logic signed [DATA_W-1:0] cap;
  assign last_col = col == CW'(FW - 1);
  assign last_row = row == RW'(FH - 1);
  assign issue = state == STREAM && ({1'b0, cnt} + {2'b0, s1_v}) < 3'd3;
  assign pop = st.out_valid && st.out_ready;
  assign head = fifo[rp];
  assign busy = state != IDLE;
  assign mem_addr = addr;
  assign st.out_valid = cnt != 2'd0;
  assign st.pixel_out = st.out_valid ? head[DATA_W+2:3] : '0;
  assign st.sof = st.out_valid && head[2];
  assign st.eol = st.out_valid && head[1];
  assign st.eof = st.out_valid && head[0];
`ifdef FRAME_STREAMER_PAD_EN
  logic border, s1_pad;
  assign border = row == '0 || last_row || col == '0 || last_col;
  assign mem_rd_en = issue && !border;
  assign cap = s1_pad ? '0 : mem_rdata;
  always_ff @(posedge clk) s1_pad <= rst ? 1'b0 : issue && border;
`else
  assign mem_rd_en = issue;
  assign cap = mem_rdata;
`endif
  always_comb begin
    state_n = state == IDLE   ? (start ? STREAM : IDLE) :
              state == STREAM ? (issue && last_row && last_col ? DRAIN : STREAM) :
                                (pop && st.eof ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      addr <= '0;
      s1_v <= 1'b0;
      s1_m <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == DRAIN && state_n == IDLE;
      s1_v <= issue;
      if (state == IDLE && start) begin
        addr <= base_addr;
        row <= '0;
        col <= '0;
      end
      if (issue) begin
        s1_m <= {row == '0 && col == '0, last_col, last_row && last_col};
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= row + RW'(1);
      end
      if (mem_rd_en) addr <= addr + ADDR_W'(1);
      if (s1_v) begin
        fifo[wp] <= {cap, s1_m};
        wp <= wp == 2'd2 ? 2'd0 : wp + 2'd1;
      end
      if (pop) rp <= rp == 2'd2 ? 2'd0 : rp + 2'd1;
      cnt <= cnt + {1'b0, s1_v} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized self-checking bench with a frame-level reference model
module tb_frame_streamer;
  localparam int W = 4;
  localparam int H = 3;
`ifdef FRAME_STREAMER_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FW = W + 2 * P;
  localparam int FH = H + 2 * P;
  localparam int N = FW * FH;
  localparam int FIRST_INT = P * (FW + 1);
  localparam int LAST_INT = (FH - 1 - P) * FW + FW - 1 - P;
  typedef struct {logic [7:0] px; logic sof, eol, eof;} pix_t;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] base_addr = '0;
  logic busy, done, mem_rd_en;
  logic [15:0] mem_addr;
  logic signed [7:0] mem_rdata = '0;
  frame_streamer_if #(.DATA_W(8)) st ();
  frame_streamer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .st(st)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];
  int errors = 0, checks = 0;
  pix_t exp_q[$];
  logic [15:0] addr_q[$];
  logic mbusy = 0, exp_done = 0, hold = 0, hs, start_ok;
  logic [10:0] prev;
  int occ = 0, acc = 0, rds = 0;
  logic [7:0] cap [64];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_frame(input logic [15:0] b);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < FW; c++) begin
        pix_t p;
        logic [15:0] a;
        a = b + 16'((r - P) * W + (c - P));
        p.sof = r == 0 && c == 0;
        p.eol = c == FW - 1;
        p.eof = r == FH - 1 && c == FW - 1;
        if (P == 1 && (r == 0 || r == FH - 1 || c == 0 || c == FW - 1)) p.px = 8'h00;
        else begin
          p.px = a[7:0];
          addr_q.push_back(a);
        end
        exp_q.push_back(p);
      end
  endtask
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, mbusy});
    chk("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_q.size() == 0) chk("valid_when_empty", {31'b0, st.out_valid}, 0);
    if (st.out_valid && exp_q.size() > 0) begin
      chk("pixel", {24'b0, st.pixel_out}, {24'b0, exp_q[0].px});
      chk("markers", {29'b0, st.sof, st.eol, st.eof}, {29'b0, exp_q[0].sof, exp_q[0].eol, exp_q[0].eof});
    end
    if (!st.out_valid) chk("idle_markers", {29'b0, st.sof, st.eol, st.eof}, 0);
    if (hold) chk("stall_stable", {21'b0, st.pixel_out, st.sof, st.eol, st.eof}, {21'b0, prev});
    if (addr_q.size() == 0) chk("read_when_none", {31'b0, mem_rd_en}, 0);
    if (mem_rd_en && addr_q.size() > 0) chk("rd_addr", {16'b0, mem_addr}, {16'b0, addr_q.pop_front()});
    if (P == 0 && occ >= 3) chk("credit_rd_en", {31'b0, mem_rd_en}, 0);
    start_ok = start && !mbusy;
    hs = st.out_valid && st.out_ready;
    exp_done = 0;
    if (mem_rd_en) rds++;
    occ = occ + int'(mem_rd_en) - int'(hs);
    if (hs && exp_q.size() > 0) begin
      if (exp_q[0].eof) begin
        exp_done = 1;
        mbusy = 0;
      end
      if (acc < 64) cap[acc] = st.pixel_out;
      acc++;
      void'(exp_q.pop_front());
    end
    hold = st.out_valid && !st.out_ready;
    prev = {st.pixel_out, st.sof, st.eol, st.eof};
    if (start_ok) begin
      push_frame(base_addr);
      mbusy = 1;
      acc = 0;
      rds = 0;
    end
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      mbusy = 0;
      exp_done = 0;
      occ = 0;
      hold = 0;
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int lim, input bit rnd, output int k);
    k = 0;
    while (!done && k < lim) begin
      if (rnd) begin
        st.out_ready = $urandom_range(0, 3) != 0;
        start = $urandom_range(0, 7) == 0;
      end
      step(1);
      k++;
    end
    start = 0;
    chk("done_timeout", {31'b0, done}, 1);
  endtask
  task automatic pulse_start(input logic [15:0] b);
    base_addr = b;
    start = 1;
    step(1);
    start = 0;
  endtask
  task automatic frame_checks(input string tag);
    chk({tag, "_count"}, acc, N);
    chk({tag, "_first"}, {24'b0, cap[FIRST_INT]}, 32'h10);
    chk({tag, "_last"}, {24'b0, cap[LAST_INT]}, 32'h1b);
  endtask
  initial begin
    int k;
    st.out_ready = 0;
    step(2);
    chk("rst_valid", {31'b0, st.out_valid}, 0);
    chk("rst_outs", {28'b0, busy, done, mem_rd_en, st.sof | st.eol | st.eof}, 0);
    chk("rst_addr", {16'b0, mem_addr}, 0);
    rst = 0;
    step(2);
    st.out_ready = 1;
    pulse_start(16'h0010);
    wait_done(300, 0, k);
    chk("t1_latency", k + 1, N + 3);
    frame_checks("t1");
    chk("t1_reads", rds, W * H);
    if (P == 1) chk("t1_border", {24'b0, cap[FW]}, 0);
    step(3);
    pulse_start(16'h0010);
    for (int i = 0; i < 300 && !done; i++) begin
      st.out_ready = (i % 4 == 0) || (i % 4 == 3);
      step(1);
    end
    chk("t2_done", {31'b0, done}, 1);
    frame_checks("t2");
    step(3);
    st.out_ready = 0;
    pulse_start(16'h0010);
    step(9);
    chk("t3_reads", rds, P == 1 ? 0 : 3);
    chk("t3_valid", {31'b0, st.out_valid}, 1);
    chk("t3_head", {24'b0, st.pixel_out}, P == 1 ? 0 : 32'h10);
    st.out_ready = 1;
    wait_done(300, 0, k);
    frame_checks("t3");
    step(3);
    pulse_start(16'h0010);
    for (int i = 0; i < 100 && acc != 5; i++) step(1);
    chk("t4_at_sixth", {31'b0, st.out_valid}, 1);
    rst = 1;
    step(1);
    rst = 0;
    chk("t4_rst_outs", {27'b0, busy, done, mem_rd_en, st.out_valid, st.sof | st.eol | st.eof}, 0);
    step(N + 5);
    chk("t4_no_done", {31'b0, done}, 0);
    pulse_start(16'h0010);
    wait_done(300, 0, k);
    frame_checks("t4");
    step(3);
    pulse_start(16'h0010);
    step(3);
    pulse_start(16'h0020);
    wait_done(300, 0, k);
    chk("t5_count", acc, N);
    pulse_start(16'h0010);
    chk("t5_back_to_back", {31'b0, busy}, 1);
    wait_done(300, 0, k);
    frame_checks("t5");
    for (int f = 0; f < 20; f++) begin
      step($urandom_range(0, 3));
      pulse_start(f % 4 == 0 ? 16'hfffa : 16'($urandom));
      wait_done(600, 1, k);
      chk("rand_count", acc, N);
    end
    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Raster-order pixel source for the convolution datapath.
- On start, reads a single-channel frame from a synchronous-read image RAM and emits it one pixel per cycle on a valid/ready stream.
- The stream carries frame and line markers and feeds the 3x3 window generator directly.
- Internal 3-entry output FIFO absorbs the RAM read latency, so the block sustains full throughput under backpressure without a combinational ready-to-read path.

Parameters:
DATA_W, 8, pixel width (signed)
IMG_W, 8, pixels per image row (>=2)
IMG_H, 8, rows per frame (>=2)
ADDR_W, 16, image RAM address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high; clock clk
start  in  1  begin a frame (sampled only in IDLE)
base_addr  in  ADDR_W  RAM address of pixel (0,0); latched on start
busy  out  1  frame in progress
done  out  1  one-cycle pulse on acceptance of the last pixel
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_W  RAM read address
mem_rdata  in  DATA_W  RAM data; valid the cycle after mem_rd_en
out_valid  out  1  pixel_out and markers valid
out_ready  in  1  downstream accepts
pixel_out  out  DATA_W  pixel (signed)
sof  out  1  first pixel of frame
eol  out  1  last pixel of row
eof  out  1  last pixel of frame

Behaviour:
- Reset values: all outputs 0, FIFO empty, in-flight slot cleared, state IDLE, row/col counters 0.
- Reset mid-frame aborts immediately; the in-flight read is discarded and no done is pulsed.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM when start=1. Latch base_addr into the address counter; row=col=0; busy goes high on the same edge.
  - STREAM: issue one read per cycle when fifo_count + s1_v < 3, using registered values only.
  - STREAM -> DRAIN on the cycle the last position (row=H-1, col=W-1) is issued.
  - DRAIN -> IDLE on the handshake (out_valid & out_ready) of the eof pixel. done=1 for exactly that following cycle; busy drops on the same edge.
- start is ignored while not in IDLE. start in the same cycle done is high is accepted, because the state is already IDLE.
- Issue stage:
  - mem_rd_en=1, mem_addr = address counter; the counter increments by 1 on each issue. No multiplier.
  - col wraps W-1 -> 0 and then increments row.
  - Marker bits are computed from row/col and registered into in-flight slot s1 with s1_v=1.
- Capture stage: the cycle after issue, {mem_rdata, markers} is pushed into the FIFO.
- FIFO pop on out_valid & out_ready.
  - Push and pop in the same cycle is legal; count is unchanged.
  - By the credit rule the FIFO never overflows.
- Output is the FIFO head. out_valid = (fifo_count != 0).
  - While out_valid & !out_ready, pixel_out and the markers hold stable.
- Latency: start sampled at edge E0; mem_rd_en high during the cycle after E0; pixel pushed at E2; out_valid high after E2.
- Throughput: 1 pixel/cycle with out_ready held high. Total accepted pixels per frame = IMG_W*IMG_H.
- Markers are asserted only with out_valid:
  - sof: row=0, col=0.
  - eol: col=W-1.
  - eof: row=H-1, col=W-1. eof implies eol.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: FRAME_STREAMER_PAD_EN.
- When defined, the block emits a 1-pixel zero border. The output frame is (IMG_W+2) x (IMG_H+2) and the counters span that range.
- Border positions occupy a normal issue slot with s1_pad=1 and mem_rd_en=0; the captured value is forced to 0.
- Interior positions read RAM in raster order, and the address counter advances only on interior issues.
- sof/eol/eof refer to the padded frame. When the macro is undefined, no padding logic exists.

Test Plan:
- IMG_W=4, IMG_H=3, base_addr=0x10, RAM[a]=a[7:0], out_ready=1, pulse start:
  - expect 12 pixels 0x10..0x1B on consecutive cycles;
  - sof on 0x10, eol on 0x13/0x17/0x1B, eof on 0x1B;
  - done one cycle after the 0x1B handshake.
- Same frame, out_ready toggled 1,0,0,1 repeating:
  - identical pixel sequence, no drop or duplicate;
  - pixel_out stable while stalled;
  - mem_rd_en never issues when fifo_count+s1_v=3.
- out_ready=0 for the entire first 10 cycles after start: exactly 3 reads issued, FIFO holds 0x10,0x11,0x12; then release -> all 12 pixels in order.
- Assert rst during the 6th pixel handshake:
  - next cycle all outputs 0, no done;
  - a new start streams the full frame from pixel 0.
- start re-pulsed while busy: ignored, 12 pixels only. start in the done cycle: a second frame begins with no gap beyond pipeline latency.
- FRAME_STREAMER_PAD_EN, IMG_W=4, IMG_H=3:
  - 30 pixels; row 0, row 4, col 0 and col 5 are zero;
  - interior equals 0x10..0x1B; eof on pixel 30;
  - RAM reads total 12.
